echo_delay_queue: RTL and testbench

- Parameterised request/indication echo block. Accepts values on `request$say`, buffers up to DEPTH of them in a FIFO, and holds each one for DELAY cycles. Each value is then presented on `indication$heard` until the consumer accepts it.
- Successor to the single-entry busy/delay echo. Adds configurable width, queue depth and delay, back-to-back throughput and an occupancy status output.
- Sits between a request-method producer and an indication-method consumer using the ENA/RDY handshake.

---
 rtl/echo_delay_queue.sv | 131 +++++++++++++
 tb/tb_echo_delay_queue.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_queue.sv
`default_nettype none
// ============================================================================
// echo_delay_queue : FIFO-buffered request->indication echo with per-entry delay
// Optional macro ECHO_DELAY_QUEUE_BYPASS_EN (empty-block bypass). Rev 1.0
// ============================================================================
module echo_delay_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int DELAY = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         request_say__ENA,
    input  logic [WIDTH-1:0]             request_say_v,
    output logic                         request_say__RDY,
    output logic                         indication_heard__ENA,
    output logic [WIDTH-1:0]             indication_heard_v,
    input  logic                         indication_heard__RDY,
    output logic [$clog2(DEPTH+1)-1:0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] out_reg;
    logic [TW-1:0]    timer;
    logic [1:0]       state;

    logic can_accept;
    logic has_data;
    logic push_req;
    logic pop;
    logic bypass;
    logic fifo_wr;

    assign can_accept = (count != CW'(DEPTH));
    assign has_data   = (count != '0);
    assign push_req   = request_say__ENA & can_accept;
    assign pop        = has_data &
                        ((state == S_IDLE) ||
                         ((state == S_PRESENT) && indication_heard__RDY));

`ifdef ECHO_DELAY_QUEUE_BYPASS_EN
    assign bypass = push_req && (state == S_IDLE) && !has_data;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_wr = push_req & ~bypass;

    // Storage array carries no reset; only entries between head and tail are ever read.
    always_ff @(posedge CLK) begin
        if (fifo_wr) begin
            mem[tail] <= request_say_v;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fifo_wr) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({fifo_wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= S_IDLE;
            out_reg <= '0;
            timer   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop || bypass) begin
                        out_reg <= pop ? mem[head] : request_say_v;
                        timer   <= TW'(DELAY - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (timer == '0) begin
                        state <= S_PRESENT;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_PRESENT: begin
                    // Reload straight into WAIT when more data is queued: no IDLE bubble.
                    if (indication_heard__RDY) begin
                        if (pop) begin
                            out_reg <= mem[head];
                            timer   <= TW'(DELAY - 1);
                            state   <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign request_say__RDY      = can_accept;
    assign indication_heard__ENA = (state == S_PRESENT);
    assign indication_heard_v    = out_reg;
    assign pending               = count;

endmodule
`default_nettype wire

// File: tb/tb_echo_delay_queue.sv
`default_nettype none
// tb_echo_delay_queue : randomized + directed check against a timestamped queue model.
module tb_echo_delay_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int DELAY = 2;
`ifdef ECHO_DELAY_QUEUE_BYPASS_EN
    localparam int LAT = DELAY;
`else
    localparam int LAT = DELAY + 1;
`endif

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             say_ena = 1'b0;
    logic [WIDTH-1:0] say_v = '0;
    logic             heard_rdy = 1'b0;
    logic             say_rdy;
    logic             heard_ena;
    logic [WIDTH-1:0] heard_v;
    logic [2:0]       pending;

    echo_delay_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY(DELAY)) dut (
        .CLK                   (clk),
        .nRST                  (nrst),
        .request_say__ENA      (say_ena),
        .request_say_v         (say_v),
        .request_say__RDY      (say_rdy),
        .indication_heard__ENA (heard_ena),
        .indication_heard_v    (heard_v),
        .indication_heard__RDY (heard_rdy),
        .pending               (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a plain queue for the FIFO plus one stage slot stamped with the edge it becomes visible.
    logic [WIDTH-1:0] mq[$];
    bit               st_valid = 1'b0;
    logic [WIDTH-1:0] st_val = '0;
    int               ready_edge = 0;
    int               edges = 0;
    int               last_push_edge = 0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            st_valid = 1'b0;
            st_val   = '0;
        end else begin
            bit presenting;
            bit do_push;
            bit released;
            int n;
            presenting = st_valid && (edges >= ready_edge);
            do_push    = say_ena && (mq.size() != DEPTH);
            released   = presenting && heard_rdy;
            n          = mq.size();
            edges++;
            if (do_push) last_push_edge = edges;
            if (released) st_valid = 1'b0;
            if ((!st_valid) && n > 0) begin
                st_val     = mq.pop_front();
                st_valid   = 1'b1;
                ready_edge = edges + DELAY;
            end
`ifdef ECHO_DELAY_QUEUE_BYPASS_EN
            else if (!presenting && !st_valid && !released && n == 0 && do_push) begin
                st_val     = say_v;
                st_valid   = 1'b1;
                ready_edge = edges + DELAY;
                do_push    = 1'b0;
            end
`endif
            if (do_push) mq.push_back(say_v);
        end
    end

    logic [WIDTH-1:0] obs[$];
    int               acc_edges[$];
    int               ena_cycles = 0;
    int               first_ena = -1;
    int               dut_accepts = 0;

    always @(negedge clk) begin
        bit exp_ena;
        exp_ena = st_valid && (edges >= ready_edge);
        chk("ena", heard_ena, exp_ena);
        if (exp_ena) chk("v", heard_v, st_val);
        chk("say_rdy", say_rdy, mq.size() != DEPTH);
        chk("pending", pending, mq.size());
        if (heard_ena === 1'b1) begin
            ena_cycles++;
            if (first_ena < 0) first_ena = edges;
            if (heard_rdy) begin
                obs.push_back(heard_v);
                acc_edges.push_back(edges);
            end
        end
        if (say_ena && say_rdy === 1'b1) dut_accepts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs.delete();
        acc_edges.delete();
        ena_cycles  = 0;
        first_ena   = -1;
        dut_accepts = 0;
    endtask

    task automatic wait_obs(int n, int budget);
        int b = 0;
        while (obs.size() < n && b < budget) begin
            tick();
            b++;
        end
        if (obs.size() < n) chk("wait_obs_timeout", obs.size(), n);
    endtask

    task automatic wait_ena(int budget);
        int b = 0;
        while (heard_ena !== 1'b1 && b < budget) begin
            tick();
            b++;
        end
        if (heard_ena !== 1'b1) chk("wait_ena_timeout", heard_ena, 1);
    endtask

    task automatic push_seq(logic [WIDTH-1:0] base, int n);
        for (int i = 0; i < n; i++) begin
            say_ena = 1'b1;
            say_v   = base + WIDTH'(i);
            tick();
        end
        say_ena = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_fp[6];
        exp_fp = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'hEE};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ena", heard_ena, 0);
        chk("rst_v", heard_v, 0);
        chk("rst_rdy", say_rdy, 1);
        chk("rst_pending", pending, 0);
        nrst = 1'b1;
        tick();

        // Latency from empty
        clear_obs();
        heard_rdy = 1'b1;
        say_ena   = 1'b1;
        say_v     = 32'h0000_00A5;
        tick();
        say_ena = 1'b0;
        repeat (8) tick();
        chk("lat_edges", first_ena - last_push_edge, LAT);
        chk("lat_ena_cycles", ena_cycles, 1);
        chk("lat_count", obs.size(), 1);
        if (obs.size() > 0) chk("lat_v", obs[0], 32'hA5);

        // Backpressure hold
        clear_obs();
        heard_rdy = 1'b0;
        push_seq(32'h55, 1);
        wait_ena(10);
        for (int i = 0; i < 7; i++) begin
            chk("bp_ena", heard_ena, 1);
            chk("bp_v", heard_v, 32'h55);
            tick();
        end
        heard_rdy = 1'b1;
        tick();
        chk("bp_popped", obs.size(), 1);
        if (obs.size() > 0) chk("bp_pop_v", obs[0], 32'h55);
        chk("bp_ena_after", heard_ena, 0);
        repeat (4) tick();

        // Fill to DEPTH+1
        clear_obs();
        heard_rdy = 1'b0;
        push_seq(32'd1, 6);
        chk("fill_accepts", dut_accepts, 5);
        chk("fill_pending", pending, 4);
        chk("fill_rdy", say_rdy, 0);
        heard_rdy = 1'b1;
        wait_obs(5, 60);
        repeat (4) tick();
        chk("fill_out_count", obs.size(), 5);
        for (int i = 0; i < 5 && i < obs.size(); i++) chk("fill_order", obs[i], i + 1);

        // Throughput and pointer wrap
        clear_obs();
        heard_rdy = 1'b1;
        begin
            int idx = 0;
            int b = 0;
            while (idx < 10 && b < 200) begin
                bit acc;
                say_ena = 1'b1;
                say_v   = WIDTH'(idx);
                acc     = say_rdy;
                tick();
                if (acc) idx++;
                b++;
            end
            say_ena = 1'b0;
        end
        wait_obs(10, 80);
        for (int i = 0; i < 10 && i < obs.size(); i++) chk("tp_order", obs[i], i);
        for (int i = 1; i < 10 && i < acc_edges.size(); i++)
            chk("tp_gap", acc_edges[i] - acc_edges[i-1], 3);
        repeat (4) tick();

        // Full with simultaneous pop
        clear_obs();
        heard_rdy = 1'b0;
        push_seq(32'h11, 5);
        wait_ena(10);
        chk("fp_pending_full", pending, 4);
        chk("fp_rdy_full", say_rdy, 0);
        heard_rdy = 1'b1;
        say_ena   = 1'b1;
        say_v     = 32'hDD;
        tick();
        chk("fp_pending_pop", pending, 3);
        chk("fp_rdy_rise", say_rdy, 1);
        heard_rdy = 1'b0;
        say_v     = 32'hEE;
        tick();
        say_ena = 1'b0;
        chk("fp_pending_refill", pending, 4);
        heard_rdy = 1'b1;
        wait_obs(6, 60);
        repeat (4) tick();
        chk("fp_out_count", obs.size(), 6);
        for (int i = 0; i < 6 && i < obs.size(); i++) chk("fp_order", obs[i], exp_fp[i]);

        // Asynchronous reset mid-operation
        clear_obs();
        heard_rdy = 1'b0;
        push_seq(32'h21, 5);
        wait_ena(10);
        heard_rdy = 1'b1;
        tick();
        heard_rdy = 1'b0;
        chk("mr_pending_before", pending, 3);
        #2;
        nrst = 1'b0;
        #1;
        chk("mr_ena", heard_ena, 0);
        chk("mr_pending", pending, 0);
        chk("mr_rdy", say_rdy, 1);
        @(negedge clk);
        #2;
        nrst = 1'b1;
        clear_obs();
        heard_rdy = 1'b1;
        repeat (12) tick();
        chk("mr_no_output", ena_cycles, 0);

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            say_ena   = ($urandom_range(0, 2) != 0);
            say_v     = $urandom;
            heard_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        say_ena   = 1'b0;
        heard_rdy = 1'b1;
        repeat (30) tick();
        chk("drain_pending", pending, 0);
        chk("drain_ena", heard_ena, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
